// File: rtl/uart_tx_cfg_if.sv
// Byte stream in, serial line and frame status out, for uart_tx_cfg.
// master = producing core / bench, slave = transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 tx_out;
  logic                 busy;
  logic                 tx_done;

  modport master (output s_data, s_valid, input s_ready, tx_out, busy, tx_done);
  modport slave  (input s_data, s_valid, output s_ready, tx_out, busy, tx_done);
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter, baud tick from a phase accumulator on clk.
// Define UART_TX_FIFO_EN to build in a FIFO_DEPTH-entry input FIFO.
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PAR    | parity bit
// STOP   | stop bit(s), high
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int ACC_WIDTH  = 20,
  parameter int BAUD_INC   = 181,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_cfg_if.slave  bus
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_cfg: illegal DATA_BITS/PARITY/STOP_BITS");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY == 1);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 tick;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 tx_q;
  logic                 done_q;
  logic                 start_go;
  logic [DATA_BITS-1:0] start_word;

  // The carry of the next sum is the tick, so the state moves on the same
  // edge the accumulator wraps.
  assign acc_sum = {1'b0, acc} + (ACC_WIDTH + 1)'(BAUD_INC);
  assign tick    = acc_sum[ACC_WIDTH];

`ifdef UART_TX_FIFO_EN
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr;
  logic [PW:0]          rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 wr_en;

  assign full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign wr_en       = bus.s_valid && !full;
  assign bus.s_ready = !full;
  assign start_go    = (state == IDLE) && !empty;
  assign start_word  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (start_go) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr[PW-1:0]] <= bus.s_data;
  end
`else
  assign bus.s_ready = (state == IDLE) && !rst;
  assign start_go    = bus.s_valid && bus.s_ready;
  assign start_word  = bus.s_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      acc    <= acc_sum[ACC_WIDTH-1:0];
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (start_go) begin
            shreg   <= start_word;
            par_bit <= (^start_word) ^ PAR_ODD;
            acc     <= '0;
            state   <= START;
            tx_q    <= 1'b0;
          end
        end
        START: if (tick) begin
          state   <= DATA;
          bit_cnt <= '0;
          tx_q    <= shreg[0];
          shreg   <= shreg >> 1;
        end
        DATA: if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            stop_cnt <= 1'b0;
            if (PARITY != 0) begin
              state <= PAR;
              tx_q  <= par_bit;
            end else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        PAR: if (tick) begin
          state    <= STOP;
          tx_q     <= 1'b1;
          stop_cnt <= 1'b0;
        end
        STOP: if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_out  = tx_q;
  assign bus.tx_done = done_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised 8-N-1 successor UART transmitter.
- Configurable data width, parity mode, stop-bit count and baud rate.
- All logic runs on the single system clock; the baud rate comes from an internal phase-accumulator tick enable, with no derived clocks.
- Sits between a byte-producing core (valid/ready stream) and the serial TX pin.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.
- ACC_WIDTH, 20: phase accumulator width.
- BAUD_INC, 181: accumulator increment per clk; bit rate = f_clk*BAUD_INC/2^ACC_WIDTH.
- FIFO_DEPTH, 8: input FIFO entries, power of two, used only with UART_TX_FIFO_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_data  input  DATA_BITS  word to transmit
- s_valid  input  1  s_data valid
- s_ready  output  1  block accepts s_data this cycle
- tx_out  output  1  serial line, idle high, registered
- busy  output  1  frame in progress (state != IDLE)
- tx_done  output  1  one-clk pulse at the end of the final stop bit

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: tx_out=1, busy=0, tx_done=0, s_ready=1, state=IDLE, accumulator=0. FIFO empties when built in.
- Baud tick: acc <= acc[ACC_WIDTH-1:0] + BAUD_INC each clk. tick = carry out of bit ACC_WIDTH.
- Accept: a transfer occurs when s_valid && s_ready at a rising clk edge.
- Without FIFO, s_ready = (state==IDLE) && !rst.
- On accept:
  - s_data is captured into a shift register.
  - acc is cleared to 0.
  - state goes to START.
  - tx_out=0 from the next clk.
- Start-bit timing: clearing acc makes the start bit exactly one bit period, with no partial first bit.
- States, advancing only on tick:
  - IDLE: tx_out=1.
  - START -> DATA: bit_cnt=0.
  - DATA: tx_out = shreg[0]; shift right on tick. After DATA_BITS ticks -> PARITY if PARITY!=0, else STOP.
  - PARITY: odd gives total ones (data+parity) odd; even gives even. Computed from the captured word -> STOP.
  - STOP: tx_out=1. stop_cnt counts STOP_BITS ticks, then -> IDLE.
- tx_done pulses high for one clk on the tick that ends the last stop bit. busy drops on the same edge.
- tx_out changes only on the clk after a tick, or on the clk after accept for the start bit. It never glitches, because it is registered.
- s_valid while busy (no FIFO): not accepted, and s_data is ignored. The producer holds it until s_ready.
- Reset mid-frame: next clk tx_out=1, state=IDLE, and the captured word is discarded. No tx_done is produced.
- Simultaneous rst and s_valid: rst wins and nothing is accepted.
- Illegal parameters (DATA_BITS outside 5..9, PARITY>2, STOP_BITS outside 1..2): elaboration-time error via a generate-time check.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined: a FIFO_DEPTH-entry input FIFO is built in.
  - s_ready = !full; a write happens when s_valid && !full.
  - When the engine is IDLE and the FIFO is not empty, it pops one word and enters START on the same edge, with acc cleared.
  - Back-to-back frames therefore have exactly one idle-high clk between the last stop bit and the next start bit.
  - A simultaneous write and pop while full is not possible (s_ready=0). While empty, the written word is stored and popped the next clk.
  - rst clears the read/write pointers.
- Undefined: no FIFO, and s_ready is high only in IDLE as above.

Test Plan:
- Basic frame:
  - Setup: ACC_WIDTH=4, BAUD_INC=4 (bit=4 clk), DATA_BITS=8, PARITY=0, STOP_BITS=1.
  - Stimulus: accept 8'hA5.
  - Required: tx_out = 0,1,0,1,0,0,1,0,1,1, each held 4 clk. tx_done pulses 40 clk after accept. s_ready=0 during the frame.
- Parity:
  - Setup: PARITY=2, word 8'h55.
  - Required: parity bit 0, frame 44 clk.
  - Setup: PARITY=1, same word.
  - Required: parity bit 1.
- Width and stop bits:
  - Setup: DATA_BITS=7, STOP_BITS=2, word 7'h41.
  - Required: 0,1,0,0,0,0,0,1,1,1. Frame 40 clk. Exactly one tx_done.
- Reset mid-frame:
  - Stimulus: assert rst at clk 10 of an 8'hFF frame.
  - Required: tx_out=1 next clk, busy=0, no tx_done, s_ready=1. The next accepted word transmits cleanly.
- Hold while busy (no FIFO):
  - Stimulus: s_valid held with 8'h3C during an active frame.
  - Required: 8'h3C is accepted the clk after tx_done. Its start bit begins at that point.
- FIFO (UART_TX_FIFO_EN, FIFO_DEPTH=4):
  - Stimulus: burst of 5 words 8'h01..8'h05 on consecutive clks.
  - Required: s_ready drops after 5 writes (1 in flight + 4 stored). All 5 frames are transmitted in order, with 1 idle clk between frames.
